// File: rtl/clk_pattern_pkg.sv
// Shared types and the config validity rule for the clock-pattern generator.
package clk_pattern_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } clk_cfg_t;

    // A period needs at least one high and one low cycle.
    function automatic logic cfg_ok(input clk_cfg_t c);
        return (c.period >= CNT_W'(2)) &&
               (c.high   >= CNT_W'(1)) &&
               (c.high   <= c.period - CNT_W'(1));
    endfunction

endpackage

// File: rtl/clk_cfg_shadow.sv
// Config handshake, validity check, active/shadow config sets and the
// period-boundary swap.
module clk_cfg_shadow
    import clk_pattern_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  clk_cfg_t         i_cfg,
    input  logic             i_idle,
    input  logic             i_swap,
    output clk_cfg_t         o_act,
    output logic             o_loaded,
    output logic [CNT_W-1:0] o_nxt_high,
    output logic             o_err
);

    clk_cfg_t r_act;
    clk_cfg_t r_pend;
    logic     r_loaded;
    logic     r_pend_valid;
    logic     r_err;
    logic     w_hs;
    logic     w_ok;

    assign o_ready    = !r_pend_valid;
    assign w_hs       = i_valid && o_ready;
    assign w_ok       = cfg_ok(i_cfg);
    assign o_act      = r_act;
    assign o_loaded   = r_loaded;
    assign o_err      = r_err;
    // High time for a HIGH entered at this boundary: the shadow wins if it
    // is about to be promoted.
    assign o_nxt_high = r_pend_valid ? r_pend.high : r_act.high;

    // Accept into active (idle) or shadow (running); promote shadow at boundary.
    // A handshake only occurs with no pending shadow, a swap only with one,
    // so the two branches never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act        <= '0;
            r_pend       <= '0;
            r_loaded     <= 1'b0;
            r_pend_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_hs && !w_ok;
            if (w_hs && w_ok) begin
                if (i_idle) begin
                    r_act    <= i_cfg;
                    r_loaded <= 1'b1;
                end else begin
                    r_pend       <= i_cfg;
                    r_pend_valid <= 1'b1;
                end
            end else if ((i_swap || i_idle) && r_pend_valid) begin
                // Idle case covers a shadow left behind by a PHASE abort.
                r_act        <= r_pend;
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_pattern_gen.sv
// Programmable divided clock: phase delay, high/low times from a single
// down-counter, registered waveform and edge strobes.
module clk_pattern_gen
    import clk_pattern_pkg::*;
(
    input  logic             clk100,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             enable,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             cfg_err,
    output logic             running
);

    clk_cfg_t         w_cfg_in;
    clk_cfg_t         w_act;
    logic             w_loaded;
    logic [CNT_W-1:0] w_nxt_high;
    logic [CNT_W-1:0] w_low;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load_val;
    logic             w_load;
    logic             w_last;
    logic             w_swap;
    logic             r_clk;
    logic             r_rise;
    logic             r_fall;

    assign w_cfg_in = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
    assign w_low    = w_act.period - w_act.high;
    assign w_last   = (r_cnt == '0);
    assign w_swap   = (r_state == LOW) && w_last;

    clk_cfg_shadow u_cfg (
        .i_clk      (clk100),
        .i_rst      (rst),
        .i_valid    (cfg_valid),
        .o_ready    (cfg_ready),
        .i_cfg      (w_cfg_in),
        .i_idle     (r_state == IDLE),
        .i_swap     (w_swap),
        .o_act      (w_act),
        .o_loaded   (w_loaded),
        .o_nxt_high (w_nxt_high),
        .o_err      (cfg_err)
    );

    // Next state and counter reload value (N-1 on every state entry).
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (enable && w_loaded) begin
                    w_load = 1'b1;
                    if (w_act.phase != '0) begin
                        w_next     = PHASE;
                        w_load_val = w_act.phase - CNT_W'(1);
                    end else begin
                        w_next     = HIGH;
                        w_load_val = w_act.high - CNT_W'(1);
                    end
                end
            end
            PHASE: begin
                if (!enable) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next     = HIGH;
                    w_load     = 1'b1;
                    w_load_val = w_act.high - CNT_W'(1);
                end
            end
            HIGH: begin
                if (w_last) begin
                    w_next     = LOW;
                    w_load     = 1'b1;
                    w_load_val = w_low - CNT_W'(1);
                end
            end
            LOW: begin
                if (w_last) begin
                    if (enable) begin
                        w_next     = HIGH;
                        w_load     = 1'b1;
                        w_load_val = w_nxt_high - CNT_W'(1);
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register and down-counter.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_cnt <= w_load_val;
            else if (!w_last)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Waveform follows the state one cycle later; strobes mark its edges.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_clk  <= (r_state == HIGH);
            r_rise <= (r_state == HIGH) && !r_clk;
            r_fall <= (r_state != HIGH) && r_clk;
        end
    end

    assign clk_out  = r_clk;
    assign rise_stb = r_rise;
    assign fall_stb = r_fall;
    assign running  = (r_state != IDLE);

endmodule
